pe_rx_checker: RTL and testbench

//  Synthesizable PE-side sink for B-tree NoC output ports; mirror of the PE traffic generator.

---
 rtl/noc_pkt_pkg.sv | 36 +++
 rtl/rx_throttle_lfsr.sv | 33 +++
 rtl/pe_rx_checker.sv | 193 +++++++++++++++++++
 tb/tb_pe_rx_checker.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noc_pkt_pkg
//  Description : Packet-format constants shared by the PE traffic generator
//                and the PE-side receive checker. Flit layout:
//                  flit[TotalWidth-1 -: AddressWidth] = destination PE
//                  payload = flit[DataWidth-1:0]
//                  payload[DataWidth-1 -: AddressWidth] = source PE
//                  payload[SeqWidth-1:0]                = sequence number
//                Also holds the throttle LFSR seed/taps and the check-result
//                record passed between the checker pipeline stages.
//  Revision    : 1.0 - initial release
// ============================================================================
package noc_pkt_pkg;

    // Sequence field sits at the bottom of the payload.
    localparam int C_SEQ_LSB           = 0;
    localparam int C_SEQ_WIDTH_DEFAULT = 16;

    // Galois LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] C_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] C_LFSR_TAPS = 16'hB400;

    // Result of checking one flit, handed from the check stage to the
    // counter stage.
    typedef struct packed {
        logic dest_err;
        logic seq_err;
    } chk_flags_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ C_LFSR_TAPS) : (s >> 1);
    endfunction

endpackage : noc_pkt_pkg
`default_nettype wire

// File: rtl/rx_throttle_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : rx_throttle_lfsr
//  Description : Free-running 16-bit LFSR that produces a ready mask with
//                roughly 75% duty (low when the two LSBs are both zero).
//                Used to apply pseudo-random backpressure to the NoC.
//  Ports       : clk          in  clock
//                rst          in  asynchronous active-high reset (reseeds)
//                o_ready_mask out 1 when the sink may assert ready
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_throttle_lfsr
    import noc_pkt_pkg::*;
(
    input  logic clk,
    input  logic rst,
    output logic o_ready_mask
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= C_LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_step(r_lfsr);
        end
    end

    assign o_ready_mask = (r_lfsr[1:0] != 2'b00);

endmodule : rx_throttle_lfsr
`default_nettype wire

// File: rtl/pe_rx_checker.sv
`default_nettype none
// ============================================================================
//  Module      : pe_rx_checker
//  Description : PE-side sink for a B-tree NoC output port. Accepts flits on
//                a valid/ready handshake, checks the destination field and
//                the per-source sequence order, counts good and bad flits,
//                and raises done once ExpectedPkts flits have arrived.
//                Pipeline: accept edge registers the flit (stage 0), next
//                edge checks it and updates the sequence table (stage 1),
//                next edge updates counters, so outputs move two cycles
//                after the accepting edge. One flit per cycle is sustained.
//  Build macro : RX_BACKPRESSURE_EN - when defined, o_data_ready is masked by
//                an LFSR (about 75% duty); otherwise ready is constant 1
//                after reset and no LFSR is built.
//  Ports       : clk, rst (async, active-high)
//                i_data[TotalWidth]   flit (dest | payload)
//                i_data_valid         flit valid
//                o_data_ready         sink ready
//                o_rx_count[32]       accepted flits, saturating
//                o_err_dest[16]       wrong-destination flits, saturating
//                o_err_seq[16]        out-of-order flits, saturating
//                o_error              sticky dest/seq/overrun error
//                o_done               sticky, rx_count reached ExpectedPkts
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_rx_checker
    import noc_pkt_pkg::*;
#(
    parameter int address      = 0,
    parameter int numPE        = 4,
    parameter int AddressWidth = 2,
    parameter int DataWidth    = 32,
    parameter int TotalWidth   = 34,
    parameter int SeqWidth     = C_SEQ_WIDTH_DEFAULT,
    parameter int ExpectedPkts = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [TotalWidth-1:0] i_data,
    input  logic                  i_data_valid,
    output logic                  o_data_ready,
    output logic [31:0]           o_rx_count,
    output logic [15:0]           o_err_dest,
    output logic [15:0]           o_err_seq,
    output logic                  o_error,
    output logic                  o_done
);

    // ------------------------------------------------------------------
    // Ready generation
    // ------------------------------------------------------------------
    logic r_run;    // goes high on the first edge after reset releases
    logic w_ready;
    logic w_accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

`ifdef RX_BACKPRESSURE_EN
    logic w_ready_mask;

    rx_throttle_lfsr u_throttle (
        .clk          (clk),
        .rst          (rst),
        .o_ready_mask (w_ready_mask)
    );

    assign w_ready = r_run & w_ready_mask;
`else
    assign w_ready = r_run;
`endif

    assign o_data_ready = w_ready;
    assign w_accept     = i_data_valid & w_ready;

    // ------------------------------------------------------------------
    // Stage 0: capture the accepted flit
    // ------------------------------------------------------------------
    logic                  r_s0_valid;
    logic [TotalWidth-1:0] r_s0_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0_valid <= 1'b0;
            r_s0_data  <= '0;
        end else begin
            r_s0_valid <= w_accept;
            if (w_accept) begin
                r_s0_data <= i_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: field decode, checks, sequence table update
    // ------------------------------------------------------------------
    logic [AddressWidth-1:0] w_dest;
    logic [AddressWidth-1:0] w_src;
    logic [SeqWidth-1:0]     w_seq;
    logic [SeqWidth-1:0]     w_exp;
    logic                    w_src_bad;
    logic                    w_dest_err;
    logic                    w_seq_err;
    logic                    w_unused_bits;

    logic [SeqWidth-1:0]     r_exp_seq [numPE];
    logic                    r_s1_valid;
    chk_flags_t              r_s1_flags;

    assign w_dest = r_s0_data[TotalWidth-1 -: AddressWidth];
    assign w_src  = r_s0_data[DataWidth-1 -: AddressWidth];
    assign w_seq  = r_s0_data[C_SEQ_LSB +: SeqWidth];

    // Payload bits between the source and sequence fields carry no meaning
    // for the checker.
    assign w_unused_bits = ^r_s0_data;

    // A source address beyond the last PE (non-power-of-2 numPE) is as
    // malformed as a wrong destination and must not index the table.
    assign w_src_bad  = (32'(w_src) >= 32'(numPE));
    assign w_dest_err = (w_dest != AddressWidth'(address)) | w_src_bad;
    assign w_exp      = r_exp_seq[w_src];
    assign w_seq_err  = ~w_dest_err & (w_seq != w_exp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_flags <= '0;
            for (int i = 0; i < numPE; i++) begin
                r_exp_seq[i] <= '0;
            end
        end else begin
            r_s1_valid          <= r_s0_valid;
            r_s1_flags.dest_err <= r_s0_valid & w_dest_err;
            r_s1_flags.seq_err  <= r_s0_valid & w_seq_err;
            // In-order and out-of-order flits both move the expectation to
            // seq+1, so a single gap produces exactly one error.
            if (r_s0_valid && !w_dest_err) begin
                r_exp_seq[w_src] <= w_seq + SeqWidth'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: saturating counters and sticky flags
    // ------------------------------------------------------------------
    logic [31:0] r_rx_count;
    logic [15:0] r_err_dest;
    logic [15:0] r_err_seq;
    logic        r_error;
    logic        r_done;
    logic [31:0] w_rx_next;

    assign w_rx_next = (&r_rx_count) ? r_rx_count : (r_rx_count + 32'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_count <= '0;
            r_err_dest <= '0;
            r_err_seq  <= '0;
            r_error    <= 1'b0;
            r_done     <= 1'b0;
        end else if (r_s1_valid) begin
            r_rx_count <= w_rx_next;
            if (r_s1_flags.dest_err && !(&r_err_dest)) begin
                r_err_dest <= r_err_dest + 16'd1;
            end
            if (r_s1_flags.seq_err && !(&r_err_seq)) begin
                r_err_seq <= r_err_seq + 16'd1;
            end
            // r_done already set means this flit is an overrun.
            if (r_s1_flags.dest_err || r_s1_flags.seq_err || r_done) begin
                r_error <= 1'b1;
            end
            if (w_rx_next == 32'(ExpectedPkts)) begin
                r_done <= 1'b1;
            end
        end
    end

    assign o_rx_count = r_rx_count;
    assign o_err_dest = r_err_dest;
    assign o_err_seq  = r_err_seq;
    assign o_error    = r_error;
    assign o_done     = r_done;

endmodule : pe_rx_checker
`default_nettype wire

// File: tb/tb_pe_rx_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_rx_checker
//  Description : Directed self-checking bench for pe_rx_checker. Instance A
//                (address 2, SeqWidth 16, ExpectedPkts 100) carries most
//                scenarios; instance B (address 2, SeqWidth 4) covers
//                sequence wrap. A select bit steers valid to one instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_rx_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic [33:0] data;
    logic        valid;
    logic        tgt;

    logic        rdy_a,   rdy_b;
    logic [31:0] rx_a,    rx_b;
    logic [15:0] ed_a,    ed_b;
    logic [15:0] es_a,    es_b;
    logic        err_a,   err_b;
    logic        done_a,  done_b;

    int n_pass    = 0;
    int n_total   = 0;
    int ready_low = 0;

    always #5 clk = ~clk;

    pe_rx_checker #(
        .address(2), .numPE(4), .AddressWidth(2), .DataWidth(32),
        .TotalWidth(34), .SeqWidth(16), .ExpectedPkts(100)
    ) u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .i_data       (data),
        .i_data_valid (valid & ~tgt),
        .o_data_ready (rdy_a),
        .o_rx_count   (rx_a),
        .o_err_dest   (ed_a),
        .o_err_seq    (es_a),
        .o_error      (err_a),
        .o_done       (done_a)
    );

    pe_rx_checker #(
        .address(2), .numPE(4), .AddressWidth(2), .DataWidth(32),
        .TotalWidth(34), .SeqWidth(4), .ExpectedPkts(1000)
    ) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .i_data       (data),
        .i_data_valid (valid & tgt),
        .o_data_ready (rdy_b),
        .o_rx_count   (rx_b),
        .o_err_dest   (ed_b),
        .o_err_seq    (es_b),
        .o_error      (err_b),
        .o_done       (done_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one flit and hold it until an edge where ready was high.
    // Returns 1 ns after the accepting edge with valid still asserted.
    task automatic send(input logic sel, input logic [1:0] dest,
                        input logic [1:0] src, input logic [15:0] seq);
        logic r;
        int   k;
        tgt   = sel;
        data  = {dest, src, 14'b0, seq};
        valid = 1'b1;
        r     = 1'b0;
        k     = 0;
        while (!r && k < 64) begin
            @(negedge clk);
            r = sel ? rdy_b : rdy_a;
            if (!r) ready_low++;
            @(posedge clk);
            #1;
            k++;
        end
        if (!r) begin
            n_total++;
            $error("FAIL send_timeout: observed ready=0 expected ready=1");
        end
    endtask

    task automatic idle();
        valid = 1'b0;
    endtask

    task automatic pulse_reset();
        valid = 1'b0;
        rst   = 1'b1;
        cycles(1);
        rst   = 1'b0;
        cycles(1);
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        tgt   = 1'b0;
        data  = '0;

        // ---------------- reset state ----------------
        cycles(2);
        check("reset_ready",  32'(rdy_a),  0);
        check("reset_rx",     rx_a,        0);
        check("reset_err",    32'(err_a),  0);
        check("reset_done",   32'(done_a), 0);
        rst = 1'b0;
        cycles(1);
`ifndef RX_BACKPRESSURE_EN
        check("ready_after_reset", 32'(rdy_a), 1);
`endif

        // ---------------- T1: 100 in-order flits ----------------
        for (int i = 0; i < 99; i++) send(1'b0, 2'd2, 2'd1, 16'(i));
        idle();
        cycles(3);
        check("t1_rx_99",   rx_a,        99);
        check("t1_done_99", 32'(done_a), 0);
        send(1'b0, 2'd2, 2'd1, 16'd99);
        idle();
        cycles(1);
        check("t1_latency_e1_rx", rx_a, 99);
        cycles(1);
        check("t1_latency_e2_rx", rx_a,        100);
        check("t1_done",          32'(done_a), 1);
        check("t1_err_dest",      32'(ed_a),   0);
        check("t1_err_seq",       32'(es_a),   0);
        check("t1_error",         32'(err_a),  0);

        // ---------------- T2: wrong destination ----------------
        send(1'b0, 2'd3, 2'd1, 16'd100);
        idle();
        cycles(3);
        check("t2_err_dest", 32'(ed_a),  1);
        check("t2_error",    32'(err_a), 1);
        check("t2_rx",       rx_a,       101);
        // Table untouched by the bad flit: seq 100 from src 1 is in order.
        send(1'b0, 2'd2, 2'd1, 16'd100);
        idle();
        cycles(3);
        check("t2_err_seq_after", 32'(es_a), 0);
        check("t2_rx_after",      rx_a,      102);

        // ---------------- T3: gap with resync, back-to-back ----------------
        send(1'b0, 2'd2, 2'd0, 16'd0);
        send(1'b0, 2'd2, 2'd0, 16'd1);
        send(1'b0, 2'd2, 2'd0, 16'd3);
        send(1'b0, 2'd2, 2'd0, 16'd4);
        idle();
        cycles(3);
        check("t3_err_seq", 32'(es_a), 1);
        check("t3_rx",      rx_a,      106);
        send(1'b0, 2'd2, 2'd0, 16'd5);
        idle();
        cycles(3);
        check("t3_exp5_clean", 32'(es_a), 1);
        check("t3_rx_after",   rx_a,      107);

        // ---------------- T4: 4-bit sequence wrap on instance B ----------------
        for (int i = 0; i < 16; i++) send(1'b1, 2'd2, 2'd1, 16'(i));
        send(1'b1, 2'd2, 2'd1, 16'd0);
        idle();
        cycles(3);
        check("t4_rx",      rx_b,       17);
        check("t4_err_seq", 32'(es_b),  0);
        check("t4_error",   32'(err_b), 0);
        send(1'b1, 2'd2, 2'd1, 16'd5);
        idle();
        cycles(3);
        check("t4_gap_err_seq", 32'(es_b),  1);
        check("t4_gap_error",   32'(err_b), 1);
        tgt = 1'b0;

        // ---------------- T5: reset mid-burst ----------------
        pulse_reset();
        for (int i = 0; i < 50; i++) send(1'b0, 2'd2, 2'd1, 16'(i));
        valid = 1'b0;
        rst   = 1'b1;
        #1;
        check("t5_rst_ready", 32'(rdy_a), 0);
        check("t5_rst_rx",    rx_a,       0);
        check("t5_rst_err_b", rx_b,       0);
        cycles(1);
        rst = 1'b0;
        cycles(4);
        check("t5_dropped_rx", rx_a,        0);
        check("t5_done",       32'(done_a), 0);
        check("t5_error",      32'(err_a),  0);
        send(1'b0, 2'd2, 2'd1, 16'd0);
        idle();
        cycles(3);
        check("t5_seq0_rx",      rx_a,       1);
        check("t5_seq0_err_seq", 32'(es_a),  0);
        check("t5_seq0_error",   32'(err_a), 0);

        // ---------------- T6: 100 flits under possible throttling ----------------
        pulse_reset();
        ready_low = 0;
        for (int i = 0; i < 100; i++) send(1'b0, 2'd2, 2'd2, 16'(i));
        idle();
        cycles(3);
        check("t6_rx",       rx_a,        100);
        check("t6_done",     32'(done_a), 1);
        check("t6_error",    32'(err_a),  0);
        check("t6_err_seq",  32'(es_a),   0);
        check("t6_err_dest", 32'(ed_a),   0);
`ifdef RX_BACKPRESSURE_EN
        check("t6_ready_toggled", 32'(ready_low > 0), 1);
`endif
        // Overrun: one more flit after done.
        send(1'b0, 2'd2, 2'd2, 16'd100);
        idle();
        cycles(3);
        check("t6_overrun_error", 32'(err_a), 1);
        check("t6_overrun_rx",    rx_a,       101);
        check("t6_overrun_seq",   32'(es_a),  0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_pe_rx_checker
`default_nettype wire
